mult_scheduler: RTL and testbench



---
 rtl/mult_pkg.sv | 19 +
 rtl/signed_multiplier.sv | 13 +
 rtl/mult_scheduler.sv | 120 ++++++++++++
 tb/tb_mult_scheduler.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the two-requester multiplier scheduler:
// operand and product widths, FSM states and requester IDs.
package mult_pkg;

   localparam int OP_W   = 5;
   localparam int PROD_W = 10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef enum logic {
      REQ_A = 1'b0,
      REQ_B = 1'b1
   } req_t;

endpackage

// File: rtl/signed_multiplier.sv
// Combinational full-precision signed multiplier shared by both requesters.
module signed_multiplier
   import mult_pkg::*;
(
   input  logic signed [OP_W-1:0]   X,
   input  logic signed [OP_W-1:0]   Y,
   output logic signed [PROD_W-1:0] Out
);

   // Sign-extend both operands first so -16 * -16 yields +256.
   assign Out = PROD_W'(X) * PROD_W'(Y);

endmodule

// File: rtl/mult_scheduler.sv
// Round-robin front end that time-shares one signed multiplier between
// requesters A and B, holding each product until its owner accepts it.
module mult_scheduler
   import mult_pkg::*;
#(
   parameter int CNT_W = 8
)
(
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              ValidA,
   input  logic [OP_W-1:0]   XA,
   input  logic [OP_W-1:0]   YA,
   output logic              ReadyA,
   output logic              RspValidA,
   input  logic              RspReadyA,
   input  logic              ValidB,
   input  logic [OP_W-1:0]   XB,
   input  logic [OP_W-1:0]   YB,
   output logic              ReadyB,
   output logic              RspValidB,
   input  logic              RspReadyB,
   output logic [PROD_W-1:0] Prod,
   output logic              Busy,
   output logic [CNT_W-1:0]  DoneCnt
);

   state_t                    state_q, state_d;
   req_t                      owner_q, owner_d;
   req_t                      lastServed_q, lastServed_d;
   logic signed [OP_W-1:0]    opX_q, opX_d;
   logic signed [OP_W-1:0]    opY_q, opY_d;
   logic signed [PROD_W-1:0]  prodReg_q, prodReg_d;
   logic [CNT_W-1:0]          doneCnt_q, doneCnt_d;
   logic signed [PROD_W-1:0]  mulOut;
   logic                      grantA;
   logic                      grantB;
   logic                      ownerTakes;

   signed_multiplier uMult (
      .X   (opX_q),
      .Y   (opY_q),
      .Out (mulOut)
   );

   // On a tie the requester that was not served last wins.
   assign grantA = ValidA && (!ValidB || (lastServed_q == REQ_B));
   assign grantB = ValidB && (!ValidA || (lastServed_q == REQ_A));

   assign ownerTakes = (owner_q == REQ_A) ? RspReadyA : RspReadyB;

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      lastServed_d = lastServed_q;
      opX_d        = opX_q;
      opY_d        = opY_q;
      prodReg_d    = prodReg_q;
      doneCnt_d    = doneCnt_q;
      ReadyA       = 1'b0;
      ReadyB       = 1'b0;
      case (state_q)
         IDLE: begin
            // Rst_n gating keeps Ready low while the block is held in reset.
            ReadyA = grantA && Rst_n;
            ReadyB = grantB && Rst_n;
            if (grantA) begin
               opX_d   = XA;
               opY_d   = YA;
               owner_d = REQ_A;
               state_d = EXEC;
            end else if (grantB) begin
               opX_d   = XB;
               opY_d   = YB;
               owner_d = REQ_B;
               state_d = EXEC;
            end
         end
         EXEC: begin
            prodReg_d = mulOut;
            state_d   = RESP;
         end
         RESP: begin
            if (ownerTakes) begin
               lastServed_d = owner_q;
               doneCnt_d    = doneCnt_q + CNT_W'(1);
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q      <= IDLE;
         owner_q      <= REQ_A;
         lastServed_q <= REQ_B;
         opX_q        <= '0;
         opY_q        <= '0;
         prodReg_q    <= '0;
         doneCnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         lastServed_q <= lastServed_d;
         opX_q        <= opX_d;
         opY_q        <= opY_d;
         prodReg_q    <= prodReg_d;
         doneCnt_q    <= doneCnt_d;
      end
   end

   assign RspValidA = (state_q == RESP) && (owner_q == REQ_A);
   assign RspValidB = (state_q == RESP) && (owner_q == REQ_B);
   assign Prod      = prodReg_q;
   assign Busy      = (state_q != IDLE);
   assign DoneCnt   = doneCnt_q;

endmodule

// File: tb/tb_mult_scheduler.sv
// Scoreboard bench for mult_scheduler: requester queues feed the DUT,
// accepted requests push expected products, responses pop and compare.
module tb_mult_scheduler;

   localparam int CNT_W = 8;

   logic             Clk = 1'b0;
   logic             Rst_n;
   logic             ValidA, ValidB;
   logic [4:0]       XA, YA, XB, YB;
   logic             ReadyA, ReadyB;
   logic             RspValidA, RspValidB;
   logic             RspReadyA, RspReadyB;
   logic [9:0]       Prod;
   logic             Busy;
   logic [CNT_W-1:0] DoneCnt;

   int testsRun    = 0;
   int testsFailed = 0;
   int qAx[$], qAy[$], qBx[$], qBy[$];
   int sbOwner[$], sbProd[$];
   int grantLog[$];
   int doneModel;
   int respCount;
   bit holdA, holdB;

   always #5 Clk = ~Clk;

   mult_scheduler #(.CNT_W(CNT_W)) dut (
      .Clk       (Clk),
      .Rst_n     (Rst_n),
      .ValidA    (ValidA),
      .XA        (XA),
      .YA        (YA),
      .ReadyA    (ReadyA),
      .RspValidA (RspValidA),
      .RspReadyA (RspReadyA),
      .ValidB    (ValidB),
      .XB        (XB),
      .YB        (YB),
      .ReadyB    (ReadyB),
      .RspValidB (RspValidB),
      .RspReadyB (RspReadyB),
      .Prod      (Prod),
      .Busy      (Busy),
      .DoneCnt   (DoneCnt)
   );

   task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                              input logic signed [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input bit req, input int x, input int y);
      if (req) begin
         qBx.push_back(x);
         qBy.push_back(y);
      end else begin
         qAx.push_back(x);
         qAy.push_back(y);
      end
   endtask

   // Each requester presents the head of its queue until it is accepted.
   task automatic refreshDrive();
      ValidA = (qAx.size() > 0);
      if (ValidA) begin
         XA = 5'(qAx[0]);
         YA = 5'(qAy[0]);
      end
      ValidB = (qBx.size() > 0);
      if (ValidB) begin
         XB = 5'(qBx[0]);
         YB = 5'(qBy[0]);
      end
      RspReadyA = !holdA;
      RspReadyB = !holdB;
   endtask

   // Observe handshakes a few ns after the negedge, then advance one clock.
   task automatic tick();
      bit hsA, hsB, rsp;
      int expOwner, expProd;
      hsA = ValidA && ReadyA;
      hsB = ValidB && ReadyB;
      rsp = (RspValidA && RspReadyA) || (RspValidB && RspReadyB);
      if (ReadyA) checkOutput("readyExclusive", ReadyB, 0);
      if (RspValidA) checkOutput("rspExclusive", RspValidB, 0);
      if (hsA) begin
         sbOwner.push_back(0);
         sbProd.push_back(int'($signed(XA)) * int'($signed(YA)));
         grantLog.push_back(0);
         qAx.delete(0);
         qAy.delete(0);
      end
      if (hsB) begin
         sbOwner.push_back(1);
         sbProd.push_back(int'($signed(XB)) * int'($signed(YB)));
         grantLog.push_back(1);
         qBx.delete(0);
         qBy.delete(0);
      end
      if (rsp) begin
         if (sbOwner.size() == 0) begin
            checkOutput("rspUnexpected", 1, 0);
         end else begin
            expOwner = sbOwner.pop_front();
            expProd  = sbProd.pop_front();
            checkOutput("rspOwner", RspValidB ? 1 : 0, expOwner);
            checkOutput("rspProd", $signed(Prod), expProd);
         end
      end
      @(posedge Clk);
      @(negedge Clk);
      if (rsp) begin
         doneModel++;
         respCount++;
         checkOutput("doneCnt", DoneCnt, doneModel % (1 << CNT_W));
      end
      refreshDrive();
      #1;
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((qAx.size() + qBx.size() + sbOwner.size()) > 0 && n < budget) begin
         tick();
         n++;
      end
      checkOutput("drainComplete", qAx.size() + qBx.size() + sbOwner.size(), 0);
   endtask

   // Reset is applied with both Valids high to show Ready stays gated.
   task automatic applyReset();
      Rst_n  = 1'b0;
      ValidA = 1'b1;
      ValidB = 1'b1;
      #1;
      checkOutput("rstReadyA", ReadyA, 0);
      checkOutput("rstReadyB", ReadyB, 0);
      checkOutput("rstRspValidA", RspValidA, 0);
      checkOutput("rstRspValidB", RspValidB, 0);
      checkOutput("rstBusy", Busy, 0);
      checkOutput("rstProd", Prod, 0);
      checkOutput("rstDoneCnt", DoneCnt, 0);
      qAx.delete();
      qAy.delete();
      qBx.delete();
      qBy.delete();
      sbOwner.delete();
      sbProd.delete();
      grantLog.delete();
      holdA     = 1'b0;
      holdB     = 1'b0;
      doneModel = 0;
      refreshDrive();
      @(posedge Clk);
      @(negedge Clk);
      Rst_n = 1'b1;
      #1;
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      int cx[4];
      int cy[4];
      cx = '{-16, -16, 0, 15};
      cy = '{-16, 15, -16, 15};
      Rst_n     = 1'b1;
      ValidA    = 1'b0;
      ValidB    = 1'b0;
      XA        = '0;
      YA        = '0;
      XB        = '0;
      YB        = '0;
      RspReadyA = 1'b1;
      RspReadyB = 1'b1;
      respCount = 0;
      #2;
      applyReset();

      $display("[TB] single request from A: 7 * -3");
      applyStimulus(0, 7, -3);
      refreshDrive();
      #1;
      checkOutput("t1ReadyA", ReadyA, 1);
      checkOutput("t1ReadyB", ReadyB, 0);
      tick();
      checkOutput("t1BusyExec", Busy, 1);
      checkOutput("t1NoRspYet", RspValidA, 0);
      tick();
      checkOutput("t1RspValidA", RspValidA, 1);
      checkOutput("t1ProdHex", Prod, 32'h3EB);
      tick();
      checkOutput("t1DoneCnt", DoneCnt, 1);
      checkOutput("t1Idle", Busy, 0);

      $display("[TB] both requesters continuously valid");
      applyReset();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, i + 1, -(i + 2));
         applyStimulus(1, -(i + 5), i + 3);
      end
      refreshDrive();
      #1;
      drain(100);
      checkOutput("grantCount", grantLog.size(), 8);
      for (int i = 0; i < grantLog.size() && i < 8; i++)
         checkOutput("grantOrder", grantLog[i], i % 2);

      $display("[TB] corner operands on each requester");
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, cx[i], cy[i]);
         applyStimulus(1, cx[i], cy[i]);
      end
      refreshDrive();
      #1;
      drain(100);

      $display("[TB] A response held for 10 cycles");
      applyStimulus(0, 5, 6);
      refreshDrive();
      #1;
      n = 0;
      while (!RspValidA && n < 6) begin
         tick();
         n++;
      end
      checkOutput("holdReached", RspValidA, 1);
      applyStimulus(1, -7, 4);
      holdA = 1'b1;
      refreshDrive();
      #1;
      for (int i = 0; i < 10; i++) begin
         checkOutput("holdRspValidA", RspValidA, 1);
         checkOutput("holdProd", $signed(Prod), 30);
         checkOutput("holdNoGrantB", ReadyB, 0);
         tick();
      end
      holdA = 1'b0;
      refreshDrive();
      #1;
      checkOutput("releaseNoGrantB", ReadyB, 0);
      tick();
      checkOutput("grantBAfterRelease", ReadyB, 1);
      drain(20);

      $display("[TB] reset during EXEC");
      applyStimulus(0, 2, 2);
      refreshDrive();
      #1;
      drain(20);
      applyStimulus(0, 3, 3);
      refreshDrive();
      #1;
      checkOutput("execReadyA", ReadyA, 1);
      tick();
      checkOutput("execBusy", Busy, 1);
      checkOutput("execNoRsp", RspValidA, 0);
      applyReset();
      for (int i = 0; i < 4; i++) begin
         checkOutput("postRstNoRsp", RspValidA, 0);
         tick();
      end
      checkOutput("postRstDoneCnt", DoneCnt, 0);
      applyStimulus(0, -4, 5);
      applyStimulus(1, 6, -2);
      refreshDrive();
      #1;
      checkOutput("tieReadyA", ReadyA, 1);
      checkOutput("tieReadyB", ReadyB, 0);
      drain(20);
      checkOutput("tieFirstGrant", (grantLog.size() > 0) ? grantLog[0] : -1, 0);

      $display("[TB] 256 back-to-back operations");
      applyReset();
      respCount = 0;
      for (int i = 0; i < 256; i++)
         applyStimulus(i[0], int'($urandom_range(31)) - 16, int'($urandom_range(31)) - 16);
      refreshDrive();
      #1;
      drain(2000);
      checkOutput("wrapDoneCnt", DoneCnt, 0);
      checkOutput("opCount", respCount, 256);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
